ysyx_22050854_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22050854_mem_arbiter
// PURPOSE
//  Shares the single 64-bit DPI-backed memory port between instruction fetch (IF, read-only) and load/store (LS, read/write).
//  Sits between the multi-cycle core (IFU/LSU) and the memory-access wrapper.
//  Serialises accesses with one transaction outstanding and returns width-adjusted responses.
//  Flags hung transactions with a timeout.
// PARAMETERS
//  LS_PRIO   1    1: LS wins simultaneous requests; 0: alternate (round-robin, LS first after reset)
//  TIMEOUT   255  cycles in WAIT without mem_rvalid before the error response; 8-bit counter
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-low reset
//  if_req       in   1   fetch request; held with if_addr until if_rvalid
//  if_addr      in   32  fetch byte address, 4-byte aligned
//  if_rvalid    out  1   1-cycle pulse: fetch response
//  if_rdata     out  32  instruction: bits[31:0] if if_addr[2]==0, else bits[63:32]
//  ls_req       in   1   load/store request; held with ls_* until ls_rvalid
//  ls_we        in   1   1 = store
//  ls_addr      in   64  data byte address
//  ls_wdata     in   64  store data
//  ls_wmask     in   64  store byte mask (0xff / 0xffff / 0xffffffff / all-ones)
//  ls_rvalid    out  1   1-cycle pulse: load data or store ack
//  ls_rdata     out  64  raw 64-bit load data; LSU performs extraction/extension
//  err          out  1   1-cycle pulse with if_rvalid/ls_rvalid on timeout
//  mem_req      out  1   downstream request, held until mem_gnt
//  mem_we       out  1   downstream write enable
//  mem_addr     out  64  downstream address (IF: {32'd0,if_addr})
//  mem_wdata    out  64  downstream write data
//  mem_wmask    out  64  downstream write mask
//  mem_gnt      in   1   downstream accepts request this cycle
//  mem_rvalid   in   1   downstream response (read data or write ack)
//  mem_rdata    in   64  downstream read data
// BEHAVIOUR
//  - Reset (rst==0 at posedge):
//    - state=IDLE, all outputs 0, counter 0, RR pointer=LS.
//    - Reset dominates every state; an in-flight transaction is dropped with no response.
//  - FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
//  - IDLE: if any req is asserted, grant per LS_PRIO/RR, latch the request into the mem_* registers, and go to REQ.
//    - mem_req rises the cycle after the req is seen.
//  - REQ: mem_req=1 with stable mem_* until mem_gnt.
//    - On mem_gnt: mem_req<=0, go to WAIT, clear counter.
//  - WAIT: mem_req=0.
//    - On mem_rvalid: capture mem_rdata, go to RESP.
//    - Otherwise count; at count==TIMEOUT go to RESP with err.
//    - mem_rvalid during the same cycle as the timeout wins, with err=0.
//    - mem_rvalid outside WAIT is ignored.
//  - RESP: pulse the granted requester's rvalid (and err if set) for exactly 1 cycle, then return to IDLE.
//    - On a timeout response, rdata = 0.
//    - The RR pointer flips to the other requester.
//  - Minimum latency: req seen at cycle N -> mem_req N+1 -> (gnt N+1, rvalid N+2) -> rvalid pulse N+3.
//  - Requester inputs are sampled only in IDLE. Changes while not granted are ignored until the next IDLE.
//  - The IF write path is tied off: mem_we=0 and mem_wmask=0 for IF grants.
//  - A requester that drops req before its response still gets its response pulse; the transaction completes.
// TESTING
//  - IF alone: if_addr=0x80000004, mem returns 0x1234_5678_9abc_def0 -> if_rdata=0x12345678, if_rvalid at cycle N+3.
//  - Simultaneous if_req/ls_req with LS_PRIO=1: LS load 0x80001000 is served first; IF starts the cycle after the LS pulse.
//  - Store: ls_we=1, ls_wmask=0xff, wdata=0xab -> mem_we=1 and mask/data match; ls_rvalid on ack; if_rvalid stays 0.
//  - mem_gnt held low 5 cycles -> mem_req stays high and mem_addr stable; the response follows normally.
//  - No mem_rvalid, TIMEOUT=4 -> err and if_rvalid pulse together, rdata=0; FSM returns to IDLE.
//  - rst low in WAIT -> next cycle all outputs 0 and no response pulse; a fresh request afterwards completes.

Source files
------------

// File: rtl/ysyx_22050854_mem_arbiter.sv
// ysyx_22050854_mem_arbiter
// Shares one 64-bit memory port between instruction fetch (IF, read-only)
// and load/store (LS, read/write). Only one transaction is outstanding at a
// time. Responses are width-adjusted per requester, and a transaction that
// never gets a memory response is closed with an error pulse.
module ysyx_22050854_mem_arbiter #(
  parameter logic       LS_PRIO = 1'b1,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [63:0] ls_wmask,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        rr_ls;      // round-robin preference: 1 = LS goes first on a tie
  logic        gnt_ls;     // requester owning the current transaction: 1 = LS
  logic        pick_ls;
  logic        wait_done;
  logic [63:0] resp_data;

  // Select the 32-bit instruction word out of a 64-bit memory beat.
  function automatic logic [31:0] fetch_word(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

  // Arbitration choice, WAIT exit condition and response payload.
  // A real response wins over the timeout; a timed-out response carries zero data.
  always_comb begin
    pick_ls   = ls_req && (!if_req || LS_PRIO || rr_ls);
    wait_done = mem_rvalid || (cnt == TIMEOUT);
    resp_data = mem_rvalid ? mem_rdata : 64'd0;
  end

  // Transaction FSM; every output is a register so nothing combinational leaks to either side.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      rr_ls     <= 1'b1;
      gnt_ls    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= 64'd0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      mem_wmask <= 64'd0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            gnt_ls  <= pick_ls;
            mem_req <= 1'b1;
            state   <= REQ;
            if (pick_ls) begin
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_wmask <= ls_wmask;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= {32'd0, if_addr};
              mem_wdata <= 64'd0;
              mem_wmask <= 64'd0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= 8'd0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            state <= RESP;
            err   <= !mem_rvalid;
            if (gnt_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= resp_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= fetch_word(resp_data, mem_addr[2]);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          rr_ls <= !gnt_ls;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mem_arbiter.sv
// Testbench for ysyx_22050854_mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters, memory and resets, all checked
// every cycle against a transaction-level timing model.
module tb_ysyx_22050854_mem_arbiter;

  localparam bit MODEL_LS_PRIO = 1'b1;
  localparam int TO            = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [63:0] ls_wmask;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_22050854_mem_arbiter #(
    .LS_PRIO (1'b1),
    .TIMEOUT (8'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_wmask   (ls_wmask),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Describes the arbiter by event times: when a request is accepted, when
  // the memory grants it, and when the response (or the timeout) is due.
  int          cyc = 0;
  int          free_at = 0;   // first edge at which a new request can be accepted
  int          gnt_cyc = 0;
  bit          busy = 0;
  bit          granted = 0;
  bit          who_ls = 0;
  bit          rr_ls = 1;
  bit          hi_word = 0;
  bit          model_valid = 0;
  bit          e_in_reset = 0;
  logic        e_mem_req = 0, e_mem_we = 0;
  logic [63:0] e_mem_addr = 0, e_mem_wdata = 0, e_mem_wmask = 0;
  logic        e_if_rvalid = 0, e_ls_rvalid = 0, e_err = 0;
  logic [31:0] e_if_rdata = 0;
  logic [63:0] e_ls_rdata = 0;

  initial begin
    logic [63:0] data;
    logic [63:0] shifted;
    forever begin
      @(posedge clk);
      cyc++;
      e_if_rvalid = 0;
      e_ls_rvalid = 0;
      e_err       = 0;
      if (!rst) begin
        model_valid = 1;
        e_in_reset  = 1;
        busy = 0; granted = 0; rr_ls = 1;
        free_at = cyc + 1;
        e_mem_req = 0; e_mem_we = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_mem_wmask = 0;
        e_if_rdata = 0; e_ls_rdata = 0;
      end else begin
        e_in_reset = 0;
        if (!busy) begin
          if (cyc >= free_at && (if_req || ls_req)) begin
            who_ls  = ls_req && (!if_req || MODEL_LS_PRIO || rr_ls);
            busy    = 1;
            granted = 0;
            e_mem_req = 1;
            if (who_ls) begin
              e_mem_we = ls_we; e_mem_addr = ls_addr;
              e_mem_wdata = ls_wdata; e_mem_wmask = ls_wmask;
            end else begin
              e_mem_we = 0; e_mem_addr = {32'd0, if_addr};
              e_mem_wdata = 0; e_mem_wmask = 0;
              hi_word = if_addr[2];
            end
          end
        end else if (!granted) begin
          if (mem_gnt) begin
            granted = 1;
            gnt_cyc = cyc;
            e_mem_req = 0;
          end
        end else if (mem_rvalid || (cyc - gnt_cyc - 1 == TO)) begin
          data  = mem_rvalid ? mem_rdata : 64'd0;
          e_err = !mem_rvalid;
          if (who_ls) begin
            e_ls_rvalid = 1;
            e_ls_rdata  = data;
          end else begin
            shifted     = data >> (hi_word ? 32 : 0);
            e_if_rvalid = 1;
            e_if_rdata  = shifted[31:0];
          end
          busy    = 0;
          free_at = cyc + 2;
          rr_ls   = !who_ls;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_valid) begin
        chk("mem_req", mem_req, e_mem_req);
        chk("if_rvalid", if_rvalid, e_if_rvalid);
        chk("ls_rvalid", ls_rvalid, e_ls_rvalid);
        chk("err", err, e_err);
        if (e_mem_req || e_in_reset) begin
          chk("mem_we", mem_we, e_mem_we);
          chk("mem_addr", mem_addr, e_mem_addr);
          chk("mem_wdata", mem_wdata, e_mem_wdata);
          chk("mem_wmask", mem_wmask, e_mem_wmask);
        end
        if (e_if_rvalid || e_in_reset) chk("if_rdata", if_rdata, e_if_rdata);
        if (e_ls_rvalid || e_in_reset) chk("ls_rdata", ls_rdata, e_ls_rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    chk("lit_reset_mem_req", mem_req, 64'd0);
    chk("lit_reset_if_rvalid", if_rvalid, 64'd0);
    chk("lit_reset_mem_addr", mem_addr, 64'd0);
    rst = 1'b1;
    tick();

    // IF alone, minimum latency, upper word
    if_req = 1; if_addr = 32'h8000_0004; mem_gnt = 1;
    tick();
    chk("lit_if_mem_req", mem_req, 64'd1);
    chk("lit_if_mem_addr", mem_addr, 64'h0000_0000_8000_0004);
    chk("lit_if_mem_we", mem_we, 64'd0);
    mem_rvalid = 1; mem_rdata = 64'h1234_5678_9abc_def0;
    tick();
    chk("lit_if_no_early_pulse", if_rvalid, 64'd0);
    tick();
    chk("lit_if_rvalid", if_rvalid, 64'd1);
    chk("lit_if_rdata", if_rdata, 64'h1234_5678);
    chk("lit_if_err", err, 64'd0);
    if_req = 0; mem_rvalid = 0;
    tick();
    chk("lit_if_pulse_end", if_rvalid, 64'd0);

    // Simultaneous requests: LS first, IF right after
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_1000; if_req = 1; if_addr = 32'h8000_0008;
    tick();
    chk("lit_sim_ls_first", mem_addr, 64'h8000_1000);
    mem_rvalid = 1; mem_rdata = 64'hdead_beef_cafe_f00d;
    tick(); tick();
    chk("lit_sim_ls_rvalid", ls_rvalid, 64'd1);
    chk("lit_sim_ls_rdata", ls_rdata, 64'hdead_beef_cafe_f00d);
    chk("lit_sim_if_quiet", if_rvalid, 64'd0);
    ls_req = 0; mem_rvalid = 0;
    tick(); tick();
    chk("lit_sim_if_mem_req", mem_req, 64'd1);
    chk("lit_sim_if_addr", mem_addr, 64'h8000_0008);
    mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
    tick(); tick();
    chk("lit_sim_if_rdata", if_rdata, 64'h3333_4444);
    if_req = 0; mem_rvalid = 0;
    tick();

    // Store
    ls_req = 1; ls_we = 1; ls_addr = 64'h8000_2000; ls_wdata = 64'hab; ls_wmask = 64'hff;
    tick();
    chk("lit_st_we", mem_we, 64'd1);
    chk("lit_st_wmask", mem_wmask, 64'hff);
    chk("lit_st_wdata", mem_wdata, 64'hab);
    mem_rvalid = 1; mem_rdata = 64'd0;
    tick(); tick();
    chk("lit_st_ack", ls_rvalid, 64'd1);
    chk("lit_st_if_quiet", if_rvalid, 64'd0);
    ls_req = 0; ls_we = 0; mem_rvalid = 0;
    tick();

    // Grant stalled for 5 cycles
    mem_gnt = 0; if_req = 1; if_addr = 32'h8000_0010;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("lit_stall_req", mem_req, 64'd1);
      chk("lit_stall_addr", mem_addr, 64'h8000_0010);
    end
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'ha5a5_0000_5a5a_ffff;
    tick(); tick();
    chk("lit_stall_rdata", if_rdata, 64'h5a5a_ffff);
    if_req = 0; mem_rvalid = 0;
    tick();

    // Timeout: no memory response
    if_req = 1; if_addr = 32'h8000_0014;
    tick(); tick();
    for (int k = 0; k < TO; k++) begin
      tick();
      chk("lit_to_wait", if_rvalid, 64'd0);
    end
    tick();
    chk("lit_to_rvalid", if_rvalid, 64'd1);
    chk("lit_to_err", err, 64'd1);
    chk("lit_to_rdata", if_rdata, 64'd0);
    if_req = 0;
    tick();
    chk("lit_to_err_end", err, 64'd0);

    // Reset in WAIT drops the transaction
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_3000;
    tick(); tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 64'hffff_ffff_ffff_ffff;
    tick();
    chk("lit_rst_mem_req", mem_req, 64'd0);
    chk("lit_rst_ls_rvalid", ls_rvalid, 64'd0);
    chk("lit_rst_mem_addr", mem_addr, 64'd0);
    tick();
    chk("lit_rst_no_pulse", ls_rvalid, 64'd0);
    rst = 1; mem_rvalid = 0;
    tick();
    chk("lit_rst_fresh_req", mem_req, 64'd1);
    mem_rvalid = 1; mem_rdata = 64'h0123_4567_89ab_cdef;
    tick(); tick();
    chk("lit_rst_fresh_rvalid", ls_rvalid, 64'd1);
    chk("lit_rst_fresh_rdata", ls_rdata, 64'h0123_4567_89ab_cdef);
    ls_req = 0; mem_rvalid = 0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (if_req) begin
        if (if_rvalid || $urandom_range(0, 31) == 0) if_req = 0;
      end else begin
        if_addr = $urandom & 32'hffff_fffc;
        if ($urandom_range(0, 3) == 0) if_req = 1;
      end
      if (ls_req) begin
        if (ls_rvalid || $urandom_range(0, 31) == 0) ls_req = 0;
      end else begin
        ls_we    = $urandom_range(0, 1);
        ls_addr  = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       ls_wmask = 64'hff;
          1:       ls_wmask = 64'hffff;
          2:       ls_wmask = 64'hffff_ffff;
          default: ls_wmask = '1;
        endcase
        if ($urandom_range(0, 3) == 0) ls_req = 1;
      end
      mem_gnt    = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = {$urandom, $urandom};
      rst        = ($urandom_range(0, 299) != 0);
      tick();
    end

    rst = 1; if_req = 0; ls_req = 0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
